// File: rtl/spr_bus_master.sv
// Single-outstanding SPR bus master: turns mtspr/mfspr requests into stb/ack bus
// transactions with a bounded wait, and returns read data or a timeout flag.
module spr_bus_master #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES       = 16
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            req_valid_i,
    input  logic                            req_we_i,
    input  logic [15:0]                     req_addr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] req_dat_i,
    output logic                            req_ready_o,

    output logic                            rsp_valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rsp_dat_o,
    output logic                            rsp_timeout_o,

    output logic [15:0]                     spr_bus_addr_o,
    output logic                            spr_bus_we_o,
    output logic                            spr_bus_stb_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
    input  logic                            spr_bus_ack_i,

    output logic                            err_spurious_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    localparam logic [7:0] CntMax = 8'(TIMEOUT_CYCLES - 1);

    state_e                          state_q, state_d;
    logic [7:0]                      cnt_q, cnt_d;
    logic [15:0]                     addr_q, addr_d;
    logic                            we_q, we_d;
    logic [OPTION_OPERAND_WIDTH-1:0] wdat_q, wdat_d;
    logic [OPTION_OPERAND_WIDTH-1:0] rdat_q, rdat_d;
    logic                            tmo_q, tmo_d;
    logic                            err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        rdat_d  = '0;
        tmo_d   = 1'b0;
        // Any ack outside an outstanding strobe is only flagged; it never moves the FSM.
        err_d   = err_q | (spr_bus_ack_i && (state_q != StReq));

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    wdat_d  = req_dat_i;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (spr_bus_ack_i) begin
                    rdat_d  = we_q ? '0 : spr_bus_dat_i;
                    state_d = StDone;
                end else if (cnt_q == CntMax) begin
                    tmo_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode from state alone; DONE is the response cycle and
    // doubles as the guaranteed strobe-low gap between transactions.
    assign req_ready_o    = (state_q == StIdle);
    assign spr_bus_stb_o  = (state_q == StReq);
    assign rsp_valid_o    = (state_q == StDone);
    assign rsp_dat_o      = rdat_q;
    assign rsp_timeout_o  = tmo_q;
    assign spr_bus_addr_o = addr_q;
    assign spr_bus_we_o   = we_q;
    assign spr_bus_dat_o  = wdat_q;
    assign err_spurious_o = err_q;

endmodule

// File: tb/tb_spr_bus_master.sv
// Randomised bench for spr_bus_master: a cycle-count model of each transaction
// predicts strobe, handshake, response and sticky-error behaviour.
module tb_spr_bus_master;

    localparam int T = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_dat;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_timeout;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic        bus_stb;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack;
    logic        err_spurious;

    int n_checks = 0;
    int n_errors = 0;
    bit err_exp = 1'b0;
    bit spur_pending = 1'b0;

    spr_bus_master #(
        .OPTION_OPERAND_WIDTH(32),
        .TIMEOUT_CYCLES      (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_dat_i     (req_dat),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_dat_o     (rsp_dat),
        .rsp_timeout_o (rsp_timeout),
        .spr_bus_addr_o(bus_addr),
        .spr_bus_we_o  (bus_we),
        .spr_bus_stb_o (bus_stb),
        .spr_bus_dat_o (bus_dat_o),
        .spr_bus_dat_i (bus_dat_i),
        .spr_bus_ack_i (bus_ack),
        .err_spurious_o(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) err_exp = 1'b0;
        else if (spur_pending) err_exp = 1'b1;
        spur_pending = 1'b0;
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    task automatic idle_cycle(input bit spur);
        req_valid = 1'b0;
        if (spur) begin
            bus_ack      = 1'b1;
            bus_dat_i    = $urandom;
            spur_pending = 1'b1;
        end
        step();
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_stb", 32'(bus_stb), 32'd0);
        check("idle_err", 32'(err_spurious), 32'(err_exp));
    endtask

    // Issues one request in the current (idle) cycle. The slave acks in stb cycle d+1
    // when d < T; otherwise the request times out after T strobe cycles.
    task automatic do_txn(input logic we, input logic [15:0] addr, input logic [31:0] wdat,
                          input int d, input logic [31:0] rd, input bit late);
        bit acked;
        int l;
        logic [31:0] exp_rd;
        acked  = (d < T);
        l      = acked ? d + 1 : T;
        exp_rd = (acked && !we) ? rd : 32'd0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_dat   = wdat;
        for (int i = 1; i <= l + 2; i++) begin
            step();
            check("stb", 32'(bus_stb), 32'(i <= l));
            check("ready", 32'(req_ready), 32'(i == l + 2));
            check("rsp_valid", 32'(rsp_valid), 32'(i == l + 1));
            check("rsp_timeout", 32'(rsp_timeout), 32'((i == l + 1) && !acked));
            check("err", 32'(err_spurious), 32'(err_exp));
            if (i == l + 1) check("rsp_dat", rsp_dat, exp_rd);
            if (i <= l) begin
                check("bus_addr", 32'(bus_addr), 32'(addr));
                check("bus_we", 32'(bus_we), 32'(we));
                check("bus_dat", bus_dat_o, wdat);
            end
            // Requests offered while busy must be ignored.
            if (i <= l + 1) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom);
                req_dat   = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            bus_dat_i = $urandom;
            if (acked && i == d + 1) begin
                bus_ack   = 1'b1;
                bus_dat_i = rd;
            end
            if (!acked && late && i == l + 1) begin
                bus_ack      = 1'b1;
                spur_pending = 1'b1;
            end
        end
    endtask

    task automatic reset_mid();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0c00;
        req_dat   = 32'h0;
        step();
        req_valid = 1'b0;
        check("mid_stb1", 32'(bus_stb), 32'd1);
        step();
        check("mid_stb2", 32'(bus_stb), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_stb_after_rst", 32'(bus_stb), 32'd0);
        check("mid_ready", 32'(req_ready), 32'd1);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_err", 32'(err_spurious), 32'd0);
        step();
        check("mid_rsp_valid2", 32'(rsp_valid), 32'd0);
        check("mid_ready2", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_dat   = '0;
        bus_dat_i = '0;
        bus_ack   = 1'b0;
        @(negedge clk);
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_stb", 32'(bus_stb), 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_dat", bus_dat_o, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_err", 32'(err_spurious), 32'd0);
        rst = 1'b0;

        do_txn(1'b0, 16'h0800, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        idle_cycle(1'b0);
        do_txn(1'b1, 16'h1000, 32'h12345678, 0, 32'hCAFEF00D, 1'b0);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        reset_mid();
        do_txn(1'b0, 16'h2000, 32'h0, T + 5, 32'h55AA55AA, 1'b1);
        do_txn(1'b0, 16'h2001, 32'h0, T - 1, 32'hA5A5A5A5, 1'b0);
        do_txn(1'b1, 16'h2002, 32'hFFFFFFFF, T, 32'h0, 1'b0);
        // Back-to-back: the next request is presented in the ready cycle itself.
        do_txn(1'b0, 16'h3000, 32'h0, 0, 32'h11112222, 1'b0);
        do_txn(1'b1, 16'h3001, 32'h33334444, 0, 32'h0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int gap;
            int d;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(T - 2, T + 2)
                                            : $urandom_range(0, 4);
            do_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, d, $urandom,
                   1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spr_bus_master.md
Name: spr_bus_master

Overview:
- Single-outstanding SPR bus master that turns mtspr/mfspr requests from the CPU control stage into SPR bus stb/ack transactions toward the SPR slaves (IMMU, DMMU, ICACHE, DCACHE).
- Sits directly upstream of the slave-side SPR interface.
- Guarantees the slave-side protocol: no back-to-back strobes, one request at a time, bounded wait via timeout.
- Returns read data, or a timeout indication, to the requester.

Parameters:
- OPTION_OPERAND_WIDTH, 32, SPR data width.
- TIMEOUT_CYCLES, 16, max strobe-high cycles without ack before abort; legal range 1..255.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid_i  input  1  request present
- req_we_i  input  1  1=mtspr (write), 0=mfspr (read)
- req_addr_i  input  16  SPR address
- req_dat_i  input  OPTION_OPERAND_WIDTH  write data
- req_ready_o  output  1  master can accept a request
- rsp_valid_o  output  1  one-cycle completion pulse
- rsp_dat_o  output  OPTION_OPERAND_WIDTH  read data (0 for writes/timeouts)
- rsp_timeout_o  output  1  qualifies rsp_valid_o: transaction aborted by timeout
- spr_bus_addr_o  output  16  SPR bus address
- spr_bus_we_o  output  1  SPR bus write enable
- spr_bus_stb_o  output  1  SPR bus strobe
- spr_bus_dat_o  output  OPTION_OPERAND_WIDTH  SPR bus write data
- spr_bus_dat_i  input  OPTION_OPERAND_WIDTH  OR-combined slave read data
- spr_bus_ack_i  input  1  OR-combined slave ack
- err_spurious_o  output  1  sticky: ack seen while no strobe outstanding

Behaviour:
- Reset: state=IDLE.
  - 0: spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o, spr_bus_dat_o, rsp_valid_o, rsp_dat_o, rsp_timeout_o, err_spurious_o, timeout counter.
  - 1: req_ready_o.
- All outputs are registered, or decoded from state only. No combinational path from any input to any output.
- FSM states IDLE, REQ, DONE.
  - IDLE: req_ready_o=1.
    - On req_valid_i: latch addr/we/dat onto spr_bus_*_o, set stb=1, clear counter, go to REQ.
  - REQ: req_ready_o=0, stb=1, addr/we/dat held stable.
    - Ack with spr_bus_ack_i=1: next cycle stb=0, rsp_valid_o=1, rsp_timeout_o=0. rsp_dat_o = we ? 0 : spr_bus_dat_i (sampled in the ack cycle). Go to DONE.
    - No ack and counter==TIMEOUT_CYCLES-1: next cycle stb=0, rsp_valid_o=1, rsp_timeout_o=1, rsp_dat_o=0. Go to DONE.
    - Otherwise: counter increments.
    - Ack in the same cycle as the timeout condition: ack wins, rsp_timeout_o=0.
  - DONE: stb=0, req_ready_o=0. Next cycle rsp_valid_o=0, rsp_timeout_o=0, go to IDLE.
    - DONE guarantees at least one cycle of stb low between transactions.
- Latency: accept at cycle N; stb high from N+1. Ack at cycle N+k gives rsp_valid_o at N+k+1 and req_ready_o high again at N+k+2.
- Back-to-back: minimum transaction period is 3 cycles (1-cycle ack). The strobe is never high in two transactions without an intervening low cycle.
- err_spurious_o is set when spr_bus_ack_i=1 and the current state is not REQ. This includes an ack arriving in DONE (late ack after a timeout).
  - A spurious ack has no other effect: no response, no state change.
  - Cleared only by rst.
- Width rules:
  - Counter is 8 bits and saturates at TIMEOUT_CYCLES-1; it does not wrap.
  - rsp_dat_o is OPTION_OPERAND_WIDTH bits, with no extension.
- Reset mid-transaction: stb drops in the cycle after rst is sampled. No response is issued for the aborted request.
- req_valid_i while req_ready_o=0 is ignored. The requester must hold it until accepted.

Test Plan:
- Read: in IDLE, req addr=0x0800, we=0. Slave acks 2 cycles after stb rises with dat_i=0xDEADBEEF. Required: stb high exactly 3 cycles, then rsp_valid_o single pulse with rsp_dat_o=0xDEADBEEF and rsp_timeout_o=0.
- Write: req we=1, addr=0x1000, dat=0x12345678, ack in the first stb cycle. Required: spr_bus_dat_o=0x12345678 and we=1 while stb high; rsp_valid_o one pulse; rsp_dat_o=0.
- Timeout: TIMEOUT_CYCLES=16, slave never acks. Required: stb high exactly 16 cycles, then rsp_valid_o=1, rsp_timeout_o=1, rsp_dat_o=0. A late ack in the following DONE cycle sets err_spurious_o=1.
- Back-to-back: req_valid_i held high with two queued requests, each 1-cycle ack. Required: stb pattern 1,0,0,1 with the second accept 3 cycles after the first; each request gets exactly one rsp_valid_o.
- Spurious ack: spr_bus_ack_i=1 for 1 cycle in IDLE. Required: err_spurious_o=1 from the next cycle until rst; no rsp_valid_o; req_ready_o stays 1.
- Reset mid-request: rst asserted on the 2nd stb-high cycle. Required: stb=0 and state IDLE the next cycle, req_ready_o=1, no rsp_valid_o, err_spurious_o=0.
